// File: rtl/wake_scoreboard.sv
// Physical-register ready scoreboard for dispatch: per-tag ready bits, wakeup countdowns,
// same-cycle wakeup bypass and intra-group dependency masking of source readiness.
module wake_scoreboard #(
    parameter int unsigned PREGS  = 64,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned LANES  = 2,
    parameter int unsigned WPORTS = 4,
    parameter int unsigned LAT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic [LANES-1:0]           disp_dst_valid,
    input  logic [LANES*TAG_W-1:0]     disp_dst_tag,
    input  logic [2*LANES*TAG_W-1:0]   disp_src_tag,
    output logic [2*LANES-1:0]         src_ready,
    input  logic [WPORTS-1:0]          wk_valid,
    input  logic [WPORTS*TAG_W-1:0]    wk_tag,
    input  logic [WPORTS*LAT_W-1:0]    wk_lat,
    output logic [PREGS-1:0]           ready_vec
);

    logic [PREGS-1:0] ready_q, ready_d;
    logic [LAT_W-1:0] cnt_q [PREGS];
    logic [LAT_W-1:0] cnt_d [PREGS];
    logic [PREGS-1:0] eff_wk, ann, clr;
    logic [LAT_W-1:0] ann_lat [PREGS];

    // Per-tag decode of wakeups, delayed announces (minimum latency wins) and dispatch clears.
    always_comb begin
        for (int p = 0; p < int'(PREGS); p++) begin
            eff_wk[p]  = (cnt_q[p] == LAT_W'(1));
            ann[p]     = 1'b0;
            ann_lat[p] = '1;
            clr[p]     = 1'b0;
            for (int w = 0; w < int'(WPORTS); w++) begin
                if (wk_valid[w] && (wk_tag[w*TAG_W +: TAG_W] == TAG_W'(p))) begin
                    if (wk_lat[w*LAT_W +: LAT_W] == '0) begin
                        eff_wk[p] = 1'b1;
                    end else begin
                        ann[p] = 1'b1;
                        if (wk_lat[w*LAT_W +: LAT_W] < ann_lat[p]) begin
                            ann_lat[p] = wk_lat[w*LAT_W +: LAT_W];
                        end
                    end
                end
            end
            for (int l = 0; l < int'(LANES); l++) begin
                if (!stall && disp_dst_valid[l] && (p != 0) &&
                    (disp_dst_tag[l*TAG_W +: TAG_W] == TAG_W'(p))) begin
                    clr[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < int'(PREGS); p++) begin
            ready_d[p] = ready_q[p];
            cnt_d[p]   = (cnt_q[p] != '0) ? cnt_q[p] - LAT_W'(1) : '0;
            if (ann[p]) begin
                cnt_d[p] = ((cnt_q[p] != '0) && (cnt_q[p] < ann_lat[p])) ? cnt_q[p] : ann_lat[p];
            end
            // Wakeup beats a new announce, which beats a dispatch clear.
            if (eff_wk[p]) begin
                ready_d[p] = 1'b1;
            end else if (!ann[p] && clr[p]) begin
                ready_d[p] = 1'b0;
                cnt_d[p]   = '0;
            end
            if (flush) begin
                ready_d[p] = 1'b1;
                cnt_d[p]   = '0;
            end
        end
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= '1;
            for (int p = 0; p < int'(PREGS); p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            ready_q <= ready_d;
            for (int p = 0; p < int'(PREGS); p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    // Sources of later lanes see earlier-lane destinations of the same group as not ready.
    always_comb begin
        logic [TAG_W-1:0] t;
        t = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int s = 0; s < 2; s++) begin
                t = disp_src_tag[(2*l+s)*TAG_W +: TAG_W];
                src_ready[2*l+s] = ready_q[t] | eff_wk[t] | (t == '0);
                for (int j = 0; j < l; j++) begin
                    if (disp_dst_valid[j] && (t != '0) &&
                        (disp_dst_tag[j*TAG_W +: TAG_W] == t)) begin
                        src_ready[2*l+s] = 1'b0;
                    end
                end
            end
        end
    end

    assign ready_vec = ready_q;

endmodule

// File: tb/tb_wake_scoreboard.sv
// Scoreboard bench for wake_scoreboard: a timestamp-based reference model queues expected
// outputs per cycle; an independent monitor pops and compares them mid-cycle.
module tb_wake_scoreboard;
    localparam int PREGS = 64, TAG_W = 6, LANES = 2, WPORTS = 4, LAT_W = 2;

    typedef struct {
        int                 cyc;
        logic [2*LANES-1:0] src;
        logic [PREGS-1:0]   rv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1, flush = 1'b0, stall = 1'b0;
    logic [LANES-1:0]         disp_dst_valid = '0;
    logic [LANES*TAG_W-1:0]   disp_dst_tag = '0;
    logic [2*LANES*TAG_W-1:0] disp_src_tag = '0;
    logic [2*LANES-1:0]       src_ready;
    logic [WPORTS-1:0]        wk_valid = '0;
    logic [WPORTS*TAG_W-1:0]  wk_tag = '0;
    logic [WPORTS*LAT_W-1:0]  wk_lat = '0;
    logic [PREGS-1:0]         ready_vec;

    // Staging copies, applied to the DUT at the next falling edge.
    logic s_rst, s_flush, s_stall;
    logic [LANES-1:0]         s_dv;
    logic [LANES*TAG_W-1:0]   s_dt;
    logic [2*LANES*TAG_W-1:0] s_st;
    logic [WPORTS-1:0]        s_wv;
    logic [WPORTS*TAG_W-1:0]  s_wt;
    logic [WPORTS*LAT_W-1:0]  s_wl;

    // Model: ready bit plus absolute cycle at which a pending wakeup fires (-1 = none).
    bit   m_ready [PREGS];
    int   wake_at [PREGS];
    int   cyc = 0;
    exp_t q[$];
    int   checks = 0, errors = 0;

    wake_scoreboard #(
        .PREGS(PREGS), .TAG_W(TAG_W), .LANES(LANES), .WPORTS(WPORTS), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .disp_dst_valid(disp_dst_valid), .disp_dst_tag(disp_dst_tag),
        .disp_src_tag(disp_src_tag), .src_ready(src_ready),
        .wk_valid(wk_valid), .wk_tag(wk_tag), .wk_lat(wk_lat), .ready_vec(ready_vec)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit   wk_now [PREGS];
        int   amin [PREGS];
        bit   clr [PREGS];
        exp_t e;
        int   t, lat, nw;
        bit   pend, r;
        if (rst) begin
            for (int p = 0; p < PREGS; p++) begin
                m_ready[p] = 1'b1;
                wake_at[p] = -1;
            end
        end
        for (int p = 0; p < PREGS; p++) begin
            wk_now[p] = (wake_at[p] == cyc);
            amin[p]   = 0;
            clr[p]    = 1'b0;
        end
        for (int w = 0; w < WPORTS; w++) begin
            if (wk_valid[w]) begin
                t   = int'(wk_tag[w*TAG_W +: TAG_W]);
                lat = int'(wk_lat[w*LAT_W +: LAT_W]);
                if (lat == 0) wk_now[t] = 1'b1;
                else if (amin[t] == 0 || lat < amin[t]) amin[t] = lat;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            t = int'(disp_dst_tag[l*TAG_W +: TAG_W]);
            if (!stall && disp_dst_valid[l] && t != 0) clr[t] = 1'b1;
        end
        e.cyc = cyc;
        for (int k = 0; k < 2*LANES; k++) begin
            t = int'(disp_src_tag[k*TAG_W +: TAG_W]);
            r = m_ready[t] || wk_now[t] || (t == 0);
            for (int j = 0; j < k/2; j++)
                if (disp_dst_valid[j] && t != 0 && int'(disp_dst_tag[j*TAG_W +: TAG_W]) == t)
                    r = 1'b0;
            e.src[k] = r;
        end
        for (int p = 0; p < PREGS; p++) e.rv[p] = m_ready[p];
        q.push_back(e);
        if (!rst) begin
            for (int p = 0; p < PREGS; p++) begin
                if (flush) begin
                    m_ready[p] = 1'b1;
                    wake_at[p] = -1;
                end else begin
                    pend = (wake_at[p] >= cyc);
                    nw   = (pend && wake_at[p] != cyc) ? wake_at[p] : -1;
                    if (amin[p] != 0)
                        nw = (pend && wake_at[p] + 1 < cyc + amin[p]) ? wake_at[p] + 1
                                                                       : cyc + amin[p];
                    if (wk_now[p]) m_ready[p] = 1'b1;
                    else if (amin[p] == 0 && clr[p]) begin
                        m_ready[p] = 1'b0;
                        nw = -1;
                    end
                    wake_at[p] = nw;
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        rst = s_rst; flush = s_flush; stall = s_stall;
        disp_dst_valid = s_dv; disp_dst_tag = s_dt; disp_src_tag = s_st;
        wk_valid = s_wv; wk_tag = s_wt; wk_lat = s_wl;
        model_step();
    endtask

    task automatic clr_stage();
        s_rst = 1'b0; s_flush = 1'b0; s_stall = 1'b0;
        s_dv = '0; s_dt = '0; s_wv = '0; s_wt = '0; s_wl = '0;
    endtask

    task automatic set_dst(input int l, input int t);
        s_dv[l] = 1'b1;
        s_dt[l*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    task automatic set_wk(input int w, input int t, input int lat);
        s_wv[w] = 1'b1;
        s_wt[w*TAG_W +: TAG_W] = TAG_W'(t);
        s_wl[w*LAT_W +: LAT_W] = LAT_W'(lat);
    endtask

    task automatic set_srcs(input int t);
        for (int k = 0; k < 2*LANES; k++) s_st[k*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            clr_stage();
            step();
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (src_ready !== e.src) begin
                    errors++;
                    $display("FAIL src_ready cyc=%0d got=%b exp=%b", e.cyc, src_ready, e.src);
                end
                checks++;
                if (ready_vec !== e.rv) begin
                    errors++;
                    $display("FAIL ready_vec cyc=%0d got=%h exp=%h", e.cyc, ready_vec, e.rv);
                end
            end
        end
    end

    initial begin
        s_st = '0;
        clr_stage();
        s_rst = 1'b1;
        set_srcs(7);
        step();
        step();
        // Clear tag 5, then read it back as a source.
        clr_stage(); set_srcs(5); set_dst(0, 5); step();
        idle(1);
        // Delayed wakeup of tag 5 with latency 2.
        clr_stage(); set_wk(2, 5, 2); step();
        idle(4);
        // Intra-group masking of tag 9, without and with stall.
        clr_stage(); set_srcs(3); s_st[2*TAG_W +: TAG_W] = TAG_W'(9);
        s_st[0 +: TAG_W] = TAG_W'(9); set_dst(0, 9); step();
        clr_stage(); s_stall = 1'b1; set_dst(0, 9); step();
        set_srcs(9); idle(2);
        // Clear vs immediate wakeup of tag 12, then clear cancelling a countdown.
        clr_stage(); set_srcs(12); set_dst(1, 12); set_wk(3, 12, 0); step();
        idle(1);
        clr_stage(); set_dst(0, 12); step();
        clr_stage(); set_wk(1, 12, 3); step();
        idle(1);
        clr_stage(); set_dst(0, 12); step();
        idle(4);
        // Two ports announce tag 20 with different latencies.
        clr_stage(); set_srcs(20); set_dst(0, 20); step();
        clr_stage(); set_wk(0, 20, 3); set_wk(1, 20, 1); step();
        idle(1);
        clr_stage(); set_dst(1, 20); step();
        idle(4);
        // Flush with ten clears and three pending countdowns.
        for (int i = 0; i < 5; i++) begin
            clr_stage(); set_dst(0, 30 + 2*i); set_dst(1, 31 + 2*i); step();
        end
        clr_stage(); set_srcs(31); set_wk(0, 30, 3); set_wk(1, 31, 3); set_wk(2, 32, 2); step();
        clr_stage(); s_flush = 1'b1; step();
        idle(4);
        // Asynchronous reset in the middle of a countdown.
        clr_stage(); set_dst(0, 40); set_dst(1, 41); step();
        clr_stage(); set_srcs(40); set_wk(0, 40, 3); set_wk(3, 41, 2); step();
        clr_stage(); s_rst = 1'b1; step();
        idle(5);
        // Randomized traffic on a narrow tag range to force collisions.
        for (int n = 0; n < 1500; n++) begin
            clr_stage();
            s_rst   = ($urandom_range(0, 99) == 0);
            s_flush = ($urandom_range(0, 49) == 0);
            s_stall = ($urandom_range(0, 4) == 0);
            for (int l = 0; l < LANES; l++)
                if ($urandom_range(0, 1) == 1) set_dst(l, $urandom_range(0, 15));
            for (int k = 0; k < 2*LANES; k++)
                s_st[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
            for (int w = 0; w < WPORTS; w++)
                if ($urandom_range(0, 2) == 0) set_wk(w, $urandom_range(0, 15), $urandom_range(0, 3));
            step();
        end
        idle(2);
        @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
